// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - registered RV32I decode stage feeding the ALU through a one-entry output register
// Optional IDU_RVE_EN: RV32E decoding (register fields with bit4 set are illegal, read-address bit4 forced to 0).
`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'b0001
`endif
`ifndef ALU_AND
`define ALU_AND  4'b0010
`endif
`ifndef ALU_OR
`define ALU_OR   4'b0011
`endif
`ifndef ALU_XOR
`define ALU_XOR  4'b0100
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'b0101
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'b1101
`endif

module idu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      rd,
  output logic            rd_wen,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_load,
  output logic            is_store,
  output logic            is_ebreak,
  output logic            illegal,
  output logic [31:0]     inst_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            wen;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            load;
    logic            store;
    logic            ebreak;
    logic            illegal;
  } bundle_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t  state, state_n;
  bundle_t dec, q;
  logic    legal, wen_raw, rve_bad, accept;

  wire [6:0] opcode = in_inst[6:0];
  wire [2:0] funct3 = in_inst[14:12];
  wire [6:0] funct7 = in_inst[31:25];

  wire [31:0] imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  wire [31:0] imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  wire [31:0] imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  wire [31:0] imm_u = {in_inst[31:12], 12'b0};
  wire [31:0] imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

`ifdef IDU_RVE_EN
  logic rd_used, rs1_used, rs2_used;
  assign rd_used  = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LUI) ||
                    (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                    (opcode == OPC_LOAD);
  assign rs1_used = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_JALR) ||
                    (opcode == OPC_BRANCH) || (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
  assign rve_bad  = (rd_used && in_inst[11]) || (rs1_used && in_inst[19]) || (rs2_used && in_inst[24]);
  assign rs1_addr = {1'b0, in_inst[18:15]};
  assign rs2_addr = {1'b0, in_inst[23:20]};
`else
  assign rve_bad  = 1'b0;
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
`endif

  always_comb begin
    dec     = '0;
    dec.op  = `ALU_ADD;
    dec.pc  = in_pc;
    dec.rd  = in_inst[11:7];
    legal   = 1'b0;
    wen_raw = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec.a   = rs1_data;
        dec.b   = rs2_data;
        wen_raw = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.op = `ALU_ADD;
            3'b100:  dec.op = `ALU_XOR;
            3'b110:  dec.op = `ALU_OR;
            3'b111:  dec.op = `ALU_AND;
            3'b010:  dec.op = `ALU_SLT;
            3'b011:  dec.op = `ALU_SLTU;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          dec.op = `ALU_SUB;
        end
      end
      OPC_OPIMM: begin
        dec.a   = rs1_data;
        dec.b   = XLEN'($signed(imm_i));
        dec.imm = XLEN'($signed(imm_i));
        wen_raw = 1'b1;
        legal   = 1'b1;
        case (funct3)
          3'b000:  dec.op = `ALU_ADD;
          3'b100:  dec.op = `ALU_XOR;
          3'b110:  dec.op = `ALU_OR;
          3'b111:  dec.op = `ALU_AND;
          3'b011:  dec.op = `ALU_SLTU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.b   = XLEN'($signed(imm_u));
        dec.imm = XLEN'($signed(imm_u));
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a   = in_pc;
        dec.b   = XLEN'($signed(imm_u));
        dec.imm = XLEN'($signed(imm_u));
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_JAL: begin
        dec.a   = in_pc;
        dec.b   = XLEN'(4);
        dec.imm = XLEN'($signed(imm_j));
        dec.jal = 1'b1;
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_JALR: begin
        dec.a    = in_pc;
        dec.b    = XLEN'(4);
        dec.imm  = XLEN'($signed(imm_i));
        dec.jalr = 1'b1;
        wen_raw  = 1'b1;
        legal    = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.op     = `ALU_SUB;
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        dec.imm    = XLEN'($signed(imm_b));
        dec.branch = 1'b1;
        legal      = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      OPC_LOAD: begin
        dec.a    = rs1_data;
        dec.b    = XLEN'($signed(imm_i));
        dec.imm  = XLEN'($signed(imm_i));
        dec.load = 1'b1;
        wen_raw  = 1'b1;
        legal    = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        dec.a     = rs1_data;
        dec.b     = XLEN'($signed(imm_s));
        dec.imm   = XLEN'($signed(imm_s));
        dec.store = 1'b1;
        legal     = (funct3 == 3'b010);
      end
      OPC_SYSTEM: begin
        dec.ebreak = (in_inst == 32'h0010_0073);
        legal      = dec.ebreak;
      end
      default: legal = 1'b0;
    endcase
    if (rve_bad) legal = 1'b0;
    // Undecodable words still flow downstream, but as an inert ADD 0,0 with no side effects.
    if (!legal) begin
      dec.op     = `ALU_ADD;
      dec.a      = '0;
      dec.b      = '0;
      dec.branch = 1'b0;
      dec.jal    = 1'b0;
      dec.jalr   = 1'b0;
      dec.load   = 1'b0;
      dec.store  = 1'b0;
      dec.ebreak = 1'b0;
      wen_raw    = 1'b0;
    end
    dec.illegal = !legal;
    dec.wen     = wen_raw && (in_inst[11:7] != 5'd0);
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (in_valid) state_n = FULL;
      FULL:    if (out_ready) state_n = in_valid ? FULL : EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  assign in_ready  = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      q        <= '0;
      inst_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        q        <= dec;
        inst_cnt <= inst_cnt + 32'd1;
      end
    end
  end

  assign alu_op    = q.op;
  assign alu_a     = q.a;
  assign alu_b     = q.b;
  assign out_pc    = q.pc;
  assign out_imm   = q.imm;
  assign rd        = q.rd;
  assign rd_wen    = q.wen;
  assign is_branch = q.branch;
  assign is_jal    = q.jal;
  assign is_jalr   = q.jalr;
  assign is_load   = q.load;
  assign is_store  = q.store;
  assign is_ebreak = q.ebreak;
  assign illegal   = q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - directed self-checking bench for idu_stage
module tb_idu_stage;

  localparam logic [3:0] E_ADD  = 4'b0000;
  localparam logic [3:0] E_SUB  = 4'b0001;
  localparam logic [3:0] E_SLTU = 4'b1101;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, out_pc, out_imm, inst_cnt;
  logic        rd_wen, is_branch, is_jal, is_jalr, is_load, is_store, is_ebreak, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .out_pc(out_pc), .out_imm(out_imm),
    .rd(rd), .rd_wen(rd_wen),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_load(is_load),
    .is_store(is_store), .is_ebreak(is_ebreak), .illegal(illegal),
    .inst_cnt(inst_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    rs1_data = '0; rs2_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", inst_cnt, 0);
    chk("rst_b", alu_b, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // addi x1,x0,5
    in_valid = 1'b1; in_inst = 32'h0050_0093; rs1_data = 0; rs2_data = 32'h55;
    #1 chk("addi_rs2_addr", rs2_addr, 5);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_op", alu_op, E_ADD);
    chk("addi_a", alu_a, 0);
    chk("addi_b", alu_b, 5);
    chk("addi_rd", rd, 1);
    chk("addi_wen", rd_wen, 1);
    chk("addi_ill", illegal, 0);
    chk("addi_cnt", inst_cnt, 1);

    // sub x3,x1,x2
    in_inst = 32'h4020_81B3; rs1_data = 7; rs2_data = 3;
    #1 chk("sub_rs1_addr", rs1_addr, 1);
    chk("sub_rs2_addr", rs2_addr, 2);
    tick();
    chk("sub_op", alu_op, E_SUB);
    chk("sub_a", alu_a, 7);
    chk("sub_b", alu_b, 3);
    chk("sub_rd", rd, 3);
    chk("sub_cnt", inst_cnt, 2);

    // sltiu x5,x1,1
    in_inst = 32'h0010_B293; rs1_data = 9;
    tick();
    chk("sltiu_op", alu_op, E_SLTU);
    chk("sltiu_a", alu_a, 9);
    chk("sltiu_b", alu_b, 1);
    chk("sltiu_rd", rd, 5);
    chk("sltiu_cnt", inst_cnt, 3);

    // stall with lui x6,0x12345 waiting; register file changes behind the held bundle
    out_ready = 1'b0; in_inst = 32'h1234_5337; in_pc = 32'h40; rs1_data = 32'hDEAD;
    #1 chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_op", alu_op, E_SLTU);
      chk("stall_a", alu_a, 9);
      chk("stall_b", alu_b, 1);
      chk("stall_rd", rd, 5);
      chk("stall_cnt", inst_cnt, 3);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("unstall_ready", in_ready, 1);
    tick();
    chk("lui_valid", out_valid, 1);
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'h1234_5000);
    chk("lui_rd", rd, 6);
    chk("lui_pc", out_pc, 32'h40);
    chk("lui_cnt", inst_cnt, 4);

    // auipc x7,1 back to back
    in_inst = 32'h0000_1397; in_pc = 32'h100;
    tick();
    chk("auipc_valid", out_valid, 1);
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    chk("auipc_rd", rd, 7);
    chk("auipc_cnt", inst_cnt, 5);

    // jal x1,8
    in_inst = 32'h0080_00EF; in_pc = 32'h200;
    tick();
    chk("jal_a", alu_a, 32'h200);
    chk("jal_b", alu_b, 4);
    chk("jal_flag", is_jal, 1);
    chk("jal_imm", out_imm, 8);
    chk("jal_wen", rd_wen, 1);

    // beq x1,x2,8
    in_inst = 32'h0020_8463; rs1_data = 32'h11; rs2_data = 32'h22;
    tick();
    chk("beq_op", alu_op, E_SUB);
    chk("beq_a", alu_a, 32'h11);
    chk("beq_b", alu_b, 32'h22);
    chk("beq_flag", is_branch, 1);
    chk("beq_wen", rd_wen, 0);
    chk("beq_imm", out_imm, 8);

    // lw x10,-4(x2)
    in_inst = 32'hFFC1_2503; rs1_data = 32'h1000;
    tick();
    chk("lw_a", alu_a, 32'h1000);
    chk("lw_b", alu_b, 32'hFFFF_FFFC);
    chk("lw_flag", is_load, 1);
    chk("lw_rd", rd, 10);
    chk("lw_wen", rd_wen, 1);

    // sw x5,12(x2)
    in_inst = 32'h0051_2623;
    tick();
    chk("sw_b", alu_b, 32'hC);
    chk("sw_flag", is_store, 1);
    chk("sw_wen", rd_wen, 0);
    chk("sw_imm", out_imm, 32'hC);

    // all-zero word
    in_inst = 32'h0000_0000; rs1_data = 32'h1234;
    tick();
    chk("zero_ill", illegal, 1);
    chk("zero_wen", rd_wen, 0);
    chk("zero_op", alu_op, E_ADD);
    chk("zero_a", alu_a, 0);
    chk("zero_b", alu_b, 0);
    chk("zero_valid", out_valid, 1);

    // mul x0,x0,x0
    in_inst = 32'h0200_0033;
    tick();
    chk("mul_ill", illegal, 1);
    chk("mul_wen", rd_wen, 0);
    chk("mul_a", alu_a, 0);

    in_inst = 32'h0010_0073;
    tick();
    chk("ebreak_flag", is_ebreak, 1);
    chk("ebreak_ill", illegal, 0);

    // addi x0,x0,1 writes nothing
    in_inst = 32'h0010_0013;
    tick();
    chk("x0_ill", illegal, 0);
    chk("x0_wen", rd_wen, 0);

    // addi x17,x0,1
    in_inst = 32'h0010_0893;
    tick();
`ifdef IDU_RVE_EN
    chk("x17_ill", illegal, 1);
    chk("x17_wen", rd_wen, 0);
`else
    chk("x17_ill", illegal, 0);
    chk("x17_rd", rd, 17);
    chk("x17_wen", rd_wen, 1);
`endif
    chk("x17_cnt", inst_cnt, 14);

    // addi x1,x17,0 presented without in_valid: address still driven
    in_valid = 1'b0; in_inst = 32'h0008_8093;
    #1;
`ifdef IDU_RVE_EN
    chk("rs1_addr_17", rs1_addr, 1);
`else
    chk("rs1_addr_17", rs1_addr, 17);
`endif
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_cnt", inst_cnt, 14);

    // reset while full and stalled
    in_valid = 1'b1; in_inst = 32'h0050_0093; rs1_data = 0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", inst_cnt, 15);
    out_ready = 1'b0;
    tick();
    chk("pre_rst_hold", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", inst_cnt, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_rd", rd, 0);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_wen", rd_wen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
